eth_rmii_rx_fcs: RTL and testbench

RMII receive front end that assembles frame bytes into DATA_BYTES-wide words, checks the Ethernet FCS and frame length, and removes the FCS from the delivered data. It sits between the 50 MHz RMII PHY pins and the MAC/packet buffer. It also reports a per-frame status word, so downstream logic no longer needs its own CRC engine.

---
 rtl/eth_pkg.sv | 38 +++
 rtl/eth_crc32_dibit.sv | 23 ++
 rtl/eth_rmii_rx_fcs.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_eth_rmii_rx_fcs.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared definitions for the RMII receive path.
// Holds the receive state encoding, the Ethernet CRC-32 constants, the
// preamble/SFD di-bit codes and the payload length helper.
package eth_pkg;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    PRE1  = 4'd1,
    PRE2  = 4'd2,
    PRE3  = 4'd3,
    DAT0  = 4'd4,
    DAT1  = 4'd5,
    DAT2  = 4'd6,
    DAT3  = 4'd7,
    HOLD  = 4'd8,
    FLUSH = 4'd9,
    EOP   = 4'd10,
    DROP  = 4'd11,
    ERR0  = 4'd12,
    ERR1  = 4'd13
  } state_t;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  // 0x55 preamble byte arrives as di-bit 01 four times; SFD 0xD5 ends with 11.
  localparam logic [1:0] DIBIT_PRE = 2'b01;
  localparam logic [1:0] DIBIT_SFD = 2'b11;

  // Payload length from the byte count (FCS included): max(cnt-4,0), saturated to 11 bits.
  function automatic logic [10:0] payload_len(input logic [11:0] cnt);
    logic [11:0] p;
    p = (cnt >= 12'd4) ? (cnt - 12'd4) : 12'd0;
    return (p > 12'd2047) ? 11'd2047 : p[10:0];
  endfunction

endpackage

// File: rtl/eth_crc32_dibit.sv
// Combinational CRC-32 (reflected, poly 0xEDB88320) advance by one RMII di-bit.
// Ports:
//   crc_i   [31:0] current CRC register
//   dibit_i [1:0]  di-bit, bit 0 is the earlier bit on the wire
//   crc_o   [31:0] CRC register after both bits
module eth_crc32_dibit
  import eth_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [1:0]  dibit_i,
  output logic [31:0] crc_o
);

  function automatic logic [31:0] crc_bit(input logic [31:0] c, input logic b);
    return (c[0] ^ b) ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
  endfunction

  // Two serial bit steps, earlier bit first.
  always_comb begin
    crc_o = crc_bit(crc_bit(crc_i, dibit_i[0]), dibit_i[1]);
  end

endmodule

// File: rtl/eth_rmii_rx_fcs.sv
// RMII receive front end: preamble/SFD detection, byte assembly, FCS check,
// FCS removal, word packing and per-frame status.
// Ports:
//   clk50, rst_n         50 MHz RMII reference clock, async active-low reset
//   rx[1:0], crs_dv      RMII receive di-bit and carrier-sense/data-valid
//   data, keep, valid    payload word (lane 0 earliest), lane mask, strobe
//   sop, eop             frame start (SFD seen) / frame end strobes
//   fcs_ok, len_err,     status, meaningful while eop=1, held until next eop
//   align_err, length
module eth_rmii_rx_fcs
  import eth_pkg::*;
#(
  parameter int DATA_BYTES = 1,
  parameter int MIN_LEN    = 64,
  parameter int MAX_LEN    = 1518
)(
  input  logic                    clk50,
  input  logic                    rst_n,
  input  logic [1:0]              rx,
  input  logic                    crs_dv,
  output logic [8*DATA_BYTES-1:0] data,
  output logic [DATA_BYTES-1:0]   keep,
  output logic                    valid,
  output logic                    sop,
  output logic                    eop,
  output logic                    fcs_ok,
  output logic                    len_err,
  output logic                    align_err,
  output logic [10:0]             length
);

  localparam int DW = 8 * DATA_BYTES;

  state_t          state_q, state_d;
  logic [5:0]      sh_q, sh_d;            // last three di-bits of the byte in flight
  logic [31:0]     crc_q, crc_d;          // running CRC, per di-bit
  logic [31:0]     crc_byte_q, crc_byte_d; // CRC at the last complete byte
  logic [11:0]     cnt_q, cnt_d;          // completed bytes, FCS included
  logic [31:0]     hb_q, hb_d;            // holdback: [7:0] newest, [31:24] oldest
  logic            align_q, align_d;
  logic            drop_q, drop_d;
  logic [1:0]      ph_q, ph_d;            // di-bit phase while dropping
  logic [DW-1:0]   pk_data_q, pk_data_d;
  logic [2:0]      pk_cnt_q, pk_cnt_d;

  logic [DW-1:0]         data_q, data_d;
  logic [DATA_BYTES-1:0] keep_q, keep_d;
  logic                  valid_q, valid_d;
  logic                  sop_q, sop_d;
  logic                  eop_q, eop_d;
  logic                  fcs_ok_q, fcs_ok_d;
  logic                  len_err_q, len_err_d;
  logic                  align_err_q, align_err_d;
  logic [10:0]           length_q, length_d;

  logic [31:0]           crc_nx_s;
  logic [7:0]            byte_s;
  logic                  rel_s;
  logic                  flush_s;
  logic                  pk_clr_s;
  logic                  full_s;
  logic [DW-1:0]         rel_word_s;
  logic [DW-1:0]         pk_data_s;
  logic [2:0]            pk_cnt_s;
  logic [DATA_BYTES-1:0] keep_part_s;

  eth_crc32_dibit u_crc (
    .crc_i   (crc_q),
    .dibit_i (rx),
    .crc_o   (crc_nx_s)
  );

  // Receive FSM: next state, byte assembly, CRC, counters and status.
  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    crc_d       = crc_q;
    crc_byte_d  = crc_byte_q;
    cnt_d       = cnt_q;
    hb_d        = hb_q;
    align_d     = align_q;
    drop_d      = drop_q;
    ph_d        = ph_q;
    sop_d       = 1'b0;
    eop_d       = 1'b0;
    fcs_ok_d    = fcs_ok_q;
    len_err_d   = len_err_q;
    align_err_d = align_err_q;
    length_d    = length_q;
    rel_s       = 1'b0;
    flush_s     = 1'b0;
    pk_clr_s    = 1'b0;
    byte_s      = {rx, sh_q};

    case (state_q)
      IDLE: begin
        if (crs_dv && (rx == DIBIT_PRE)) begin
          state_d = PRE1;
        end else begin
          state_d = IDLE;
        end
      end
      PRE1: begin
        state_d = (rx == DIBIT_PRE) ? PRE2 : ERR0;
      end
      PRE2: begin
        state_d = (rx == DIBIT_PRE) ? PRE3 : ERR0;
      end
      PRE3: begin
        if (rx == DIBIT_SFD) begin
          state_d    = DAT0;
          sop_d      = 1'b1;
          crc_d      = CRC32_INIT;
          crc_byte_d = CRC32_INIT;
          cnt_d      = 12'd0;
          hb_d       = 32'd0;
          align_d    = 1'b0;
          drop_d     = 1'b0;
          pk_clr_s   = 1'b1;
        end else if (rx == DIBIT_PRE) begin
          state_d = PRE3;
        end else begin
          state_d = ERR0;
        end
      end
      DAT0, DAT2: begin
        sh_d    = byte_s[7:2];
        crc_d   = crc_nx_s;
        state_d = (state_q == DAT0) ? DAT1 : DAT3;
      end
      DAT1: begin
        sh_d  = byte_s[7:2];
        crc_d = crc_nx_s;
        if (!crs_dv) begin
          // Carrier lost mid-byte: the half byte is dropped.
          align_d = 1'b1;
          flush_s = 1'b1;
          state_d = FLUSH;
        end else begin
          state_d = DAT2;
        end
      end
      DAT3: begin
        sh_d       = byte_s[7:2];
        crc_d      = crc_nx_s;
        crc_byte_d = crc_nx_s;
        cnt_d      = cnt_q + 12'd1;
        if (cnt_d == 12'(MAX_LEN + 1)) begin
          // Oversize: nothing more is released; ride out the carrier.
          drop_d  = 1'b1;
          ph_d    = 2'd0;
          flush_s = !crs_dv;
          state_d = crs_dv ? DROP : FLUSH;
        end else begin
          hb_d    = {hb_q[23:0], byte_s};
          rel_s   = (cnt_q >= 12'd4);
          flush_s = !crs_dv;
          state_d = crs_dv ? DAT0 : FLUSH;
        end
      end
      DROP: begin
        ph_d = ph_q + 2'd1;
        if (ph_q[0] && !crs_dv) begin
          // Deliver whatever the packer still holds before reporting.
          flush_s = 1'b1;
          state_d = FLUSH;
        end else begin
          state_d = DROP;
        end
      end
      FLUSH: begin
        eop_d       = 1'b1;
        fcs_ok_d    = !drop_q && (crc_byte_q == CRC32_RESIDUE);
        len_err_d   = drop_q || (cnt_q < 12'(MIN_LEN)) || (cnt_q > 12'(MAX_LEN));
        align_err_d = align_q;
        length_d    = drop_q ? 11'(MAX_LEN - 4) : payload_len(cnt_q);
        state_d     = EOP;
      end
      EOP: begin
        state_d = IDLE;
      end
      ERR0: begin
        state_d = crs_dv ? ERR0 : ERR1;
      end
      ERR1: begin
        state_d = crs_dv ? ERR0 : IDLE;
      end
      default: begin
        // HOLD and unused encodings are never entered; recover to IDLE.
        state_d = IDLE;
      end
    endcase
  end

  // Word packer: place a released byte, emit full words and the final partial word.
  always_comb begin
    rel_word_s      = '0;
    rel_word_s[7:0] = hb_q[31:24];

    if (pk_clr_s) begin
      pk_data_s = '0;
      pk_cnt_s  = 3'd0;
    end else if (rel_s) begin
      // Lanes above pk_cnt_q are always zero, so OR-in is a lane write.
      pk_data_s = pk_data_q | (rel_word_s << {pk_cnt_q, 3'b000});
      pk_cnt_s  = pk_cnt_q + 3'd1;
    end else begin
      pk_data_s = pk_data_q;
      pk_cnt_s  = pk_cnt_q;
    end

    full_s = rel_s && (pk_cnt_q == 3'(DATA_BYTES - 1));

    for (int l = 0; l < DATA_BYTES; l++) begin
      keep_part_s[l] = (3'(l) < pk_cnt_s);
    end

    if (full_s) begin
      data_d    = pk_data_s;
      keep_d    = '1;
      valid_d   = 1'b1;
      pk_data_d = '0;
      pk_cnt_d  = 3'd0;
    end else if (flush_s && (pk_cnt_s != 3'd0)) begin
      data_d    = pk_data_s;
      keep_d    = keep_part_s;
      valid_d   = 1'b1;
      pk_data_d = '0;
      pk_cnt_d  = 3'd0;
    end else begin
      data_d    = data_q;
      keep_d    = keep_q;
      valid_d   = 1'b0;
      pk_data_d = pk_data_s;
      pk_cnt_d  = pk_cnt_s;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sh_q        <= 6'd0;
      crc_q       <= CRC32_INIT;
      crc_byte_q  <= CRC32_INIT;
      cnt_q       <= 12'd0;
      hb_q        <= 32'd0;
      align_q     <= 1'b0;
      drop_q      <= 1'b0;
      ph_q        <= 2'd0;
      pk_data_q   <= '0;
      pk_cnt_q    <= 3'd0;
      data_q      <= '0;
      keep_q      <= '0;
      valid_q     <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      fcs_ok_q    <= 1'b0;
      len_err_q   <= 1'b0;
      align_err_q <= 1'b0;
      length_q    <= 11'd0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      crc_q       <= crc_d;
      crc_byte_q  <= crc_byte_d;
      cnt_q       <= cnt_d;
      hb_q        <= hb_d;
      align_q     <= align_d;
      drop_q      <= drop_d;
      ph_q        <= ph_d;
      pk_data_q   <= pk_data_d;
      pk_cnt_q    <= pk_cnt_d;
      data_q      <= data_d;
      keep_q      <= keep_d;
      valid_q     <= valid_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      fcs_ok_q    <= fcs_ok_d;
      len_err_q   <= len_err_d;
      align_err_q <= align_err_d;
      length_q    <= length_d;
    end
  end

  assign data      = data_q;
  assign keep      = keep_q;
  assign valid     = valid_q;
  assign sop       = sop_q;
  assign eop       = eop_q;
  assign fcs_ok    = fcs_ok_q;
  assign len_err   = len_err_q;
  assign align_err = align_err_q;
  assign length    = length_q;

endmodule

// File: tb/tb_eth_rmii_rx_fcs.sv
// Self-checking bench for eth_rmii_rx_fcs (DATA_BYTES=4, MIN_LEN=64, MAX_LEN=1518).
// Frames are built as byte queues, sent as RMII di-bits, and the captured
// word stream and status are compared with a byte-level reference model.
module tb_eth_rmii_rx_fcs;
  import eth_pkg::*;

  localparam int DB    = 4;
  localparam int MIN_L = 64;
  localparam int MAX_L = 1518;

  logic        clk50  = 1'b0;
  logic        rst_n  = 1'b0;
  logic [1:0]  rx     = 2'b00;
  logic        crs_dv = 1'b0;
  logic [31:0] data;
  logic [3:0]  keep;
  logic        valid, sop, eop, fcs_ok, len_err, align_err;
  logic [10:0] length;

  eth_rmii_rx_fcs #(.DATA_BYTES(DB), .MIN_LEN(MIN_L), .MAX_LEN(MAX_L)) dut (
    .clk50(clk50), .rst_n(rst_n), .rx(rx), .crs_dv(crs_dv),
    .data(data), .keep(keep), .valid(valid), .sop(sop), .eop(eop),
    .fcs_ok(fcs_ok), .len_err(len_err), .align_err(align_err), .length(length)
  );

  always #10 clk50 = ~clk50;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  fb[$];
  logic [31:0] got_data[$];
  logic [3:0]  got_keep[$];
  int          sop_cnt = 0, eop_cnt = 0, both_cnt = 0;
  logic        st_fcs = 1'b0, st_len = 1'b0, st_align = 1'b0;
  logic [10:0] st_length = 11'd0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Capture of everything the DUT emits.
  always @(negedge clk50) begin
    if (rst_n) begin
      if (valid) begin
        got_data.push_back(data);
        got_keep.push_back(keep);
      end
      if (sop) sop_cnt++;
      if (eop) begin
        eop_cnt++;
        st_fcs    = fcs_ok;
        st_len    = len_err;
        st_align  = align_err;
        st_length = length;
      end
      if (valid && eop) both_cnt++;
    end
  end

  function automatic logic [31:0] crc32_ref(input int len);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < len; i++) begin
      c = c ^ {24'd0, fb[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // n bytes total; the last four are the FCS of the rest, optionally with a payload bit flipped.
  task automatic make_frame(input int n, input bit flip);
    logic [31:0] c;
    int          p;
    fb.delete();
    if (n < 4) begin
      for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
    end else begin
      for (int i = 0; i < n - 4; i++) fb.push_back(8'($urandom));
      c = crc32_ref(n - 4);
      for (int i = 0; i < 4; i++) fb.push_back(c[8*i +: 8]);
      if (flip && n > 4) begin
        p = $urandom_range(0, n - 5);
        fb[p] = fb[p] ^ (8'd1 << $urandom_range(0, 7));
      end
    end
  endtask

  task automatic drive(input logic [1:0] d, input logic dv);
    @(negedge clk50);
    rx     = d;
    crs_dv = dv;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "/data"}, data, 0);
    chk({tag, "/keep"}, keep, 0);
    chk({tag, "/valid"}, valid, 0);
    chk({tag, "/sop"}, sop, 0);
    chk({tag, "/eop"}, eop, 0);
    chk({tag, "/fcs_ok"}, fcs_ok, 0);
    chk({tag, "/len_err"}, len_err, 0);
    chk({tag, "/align_err"}, align_err, 0);
    chk({tag, "/length"}, length, 0);
  endtask

  // Preamble + SFD, n_full complete bytes, optional half byte, then idle gap.
  // abort_byte >= 0 pulses rst_n after one di-bit of that byte.
  task automatic send(input int n_full, input bit align, input int abort_byte);
    logic [7:0] b;
    bit         stop;
    stop = 1'b0;
    for (int i = 0; i < 28; i++) drive(2'b01, 1'b1);
    drive(2'b01, 1'b1); drive(2'b01, 1'b1); drive(2'b01, 1'b1); drive(2'b11, 1'b1);
    for (int i = 0; i < n_full && !stop; i++) begin
      b = fb[i];
      if (i == abort_byte) begin
        drive(b[1:0], 1'b1);
        #3 rst_n = 1'b0;
        #2 chk_zero("rst_mid");
        drive(2'b00, 1'b0);
        drive(2'b00, 1'b0);
        rst_n = 1'b1;
        stop  = 1'b1;
      end else begin
        for (int k = 0; k < 4; k++)
          drive(b[2*k +: 2], !(!align && i == n_full - 1 && k == 3));
      end
    end
    if (align && !stop) begin
      drive(2'($urandom), 1'b1);
      drive(2'($urandom), 1'b0);
    end
    repeat (12) drive(2'b00, 1'b0);
  endtask

  task automatic expect_frame(input string tag, input int n, input bit align,
                              input int sop0, input int eop0);
    int          deliver, nwords, idx;
    logic [31:0] ew, c;
    logic [3:0]  ek;
    bit          ok;
    deliver = (n > MAX_L) ? MAX_L - 4 : ((n > 4) ? n - 4 : 0);
    nwords  = (deliver + DB - 1) / DB;
    chk({tag, "/sops"}, sop_cnt - sop0, 1);
    chk({tag, "/eops"}, eop_cnt - eop0, 1);
    chk({tag, "/words"}, got_data.size(), nwords);
    for (int w = 0; w < nwords; w++) begin
      if (w < got_data.size()) begin
        ew = 32'd0;
        ek = 4'd0;
        for (int l = 0; l < DB; l++) begin
          idx = w * DB + l;
          if (idx < deliver) begin
            ew[8*l +: 8] = fb[idx];
            ek[l]        = 1'b1;
          end
        end
        chk($sformatf("%s/data%0d", tag, w), got_data[w], ew);
        chk($sformatf("%s/keep%0d", tag, w), got_keep[w], ek);
      end
    end
    chk({tag, "/valid_eop_overlap"}, both_cnt, 0);
    ok = 1'b0;
    if (n >= 4 && n <= MAX_L) begin
      c  = crc32_ref(n - 4);
      ok = (c == {fb[n-1], fb[n-2], fb[n-3], fb[n-4]});
    end
    chk({tag, "/fcs_ok"}, st_fcs, ok);
    chk({tag, "/len_err"}, st_len, (n < MIN_L) || (n > MAX_L));
    chk({tag, "/align_err"}, st_align, align);
    chk({tag, "/length"}, st_length, (n > MAX_L) ? MAX_L - 4 : ((n >= 4) ? n - 4 : 0));
    got_data.delete();
    got_keep.delete();
  endtask

  task automatic run(input string tag, input int n, input bit flip, input bit align);
    int s0, e0;
    make_frame(n, flip);
    s0 = sop_cnt;
    e0 = eop_cnt;
    send(n, align, -1);
    expect_frame(tag, n, align, s0, e0);
  endtask

  initial begin
    int s0, e0;
    repeat (3) @(negedge clk50);
    chk_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk50);

    run("len64", 64, 1'b0, 1'b0);
    run("len67", 67, 1'b0, 1'b0);
    run("len67_flip", 67, 1'b1, 1'b0);
    run("oversize", 1600, 1'b0, 1'b0);
    run("len_max", 1518, 1'b0, 1'b0);
    run("len_min_m1", 63, 1'b0, 1'b0);
    run("align", 66, 1'b0, 1'b1);
    run("tiny", 3, 1'b0, 1'b0);
    run("four", 4, 1'b0, 1'b0);

    // Corrupted preamble: no sop/eop, back to IDLE after two low cycles.
    s0 = sop_cnt;
    e0 = eop_cnt;
    drive(2'b01, 1'b1); drive(2'b01, 1'b1); drive(2'b10, 1'b1); drive(2'b00, 1'b1);
    drive(2'b00, 1'b0); drive(2'b00, 1'b0);
    chk("pre_err/st_err1", dut.state_q, ERR1);
    drive(2'b00, 1'b0);
    chk("pre_err/st_idle", dut.state_q, IDLE);
    repeat (10) drive(2'b00, 1'b0);
    chk("pre_err/sops", sop_cnt - s0, 0);
    chk("pre_err/eops", eop_cnt - e0, 0);
    chk("pre_err/words", got_data.size(), 0);

    // Reset mid-payload: outputs clear at once, no eop, next frame clean.
    make_frame(100, 1'b0);
    s0 = sop_cnt;
    e0 = eop_cnt;
    send(100, 1'b0, 40);
    chk("rst_abort/sops", sop_cnt - s0, 1);
    chk("rst_abort/eops", eop_cnt - e0, 0);
    got_data.delete();
    got_keep.delete();
    run("after_rst", 80, 1'b0, 1'b0);

    for (int r = 0; r < 10; r++) begin
      int kind;
      kind = $urandom_range(0, 2);
      run($sformatf("rnd%0d", r), $urandom_range(5, 160), kind == 1, kind == 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
